// File: rtl/merge_2to1.sv
// Two-input descending run merger: one record per cycle, pops combinational, output registered (latency 1).
// Stalls with no pops while downstream is almost full or a needed input is empty; MERGE_2TO1_STATS_EN adds counters.
module merge_2to1 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_item_a,
    input  logic                  i_empty_a,
    output logic                  o_read_a,
    input  logic [DATA_WIDTH-1:0] i_item_b,
    input  logic                  i_empty_b,
    output logic                  o_read_b,
    input  logic                  i_full,
    output logic [DATA_WIDTH-1:0] o_item,
    output logic                  o_write,
    output logic [1:0]            o_state
`ifdef MERGE_2TO1_STATS_EN
    ,
    output logic [31:0]           o_rec_count,
    output logic [15:0]           o_run_count
`endif
);

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  go;
    logic                  pop_a;
    logic                  pop_b;
    logic                  emit;
    logic [DATA_WIDTH-1:0] emit_dat;
    logic                  a_zero;
    logic                  b_zero;

    assign go     = !i_full;
    assign a_zero = (i_item_a == '0);
    assign b_zero = (i_item_b == '0);

    always_comb begin
        state_nxt = state;
        pop_a     = 1'b0;
        pop_b     = 1'b0;
        emit      = 1'b0;
        emit_dat  = '0;
        case (state)
            MERGE: begin
                if (go && !i_empty_a && !i_empty_b) begin
                    if (a_zero && b_zero) begin
                        pop_a = 1'b1;
                        pop_b = 1'b1;
                        emit  = 1'b1;
                    end else if (a_zero) begin
                        // A's run ended first; its terminator is swallowed, B's will be emitted
                        pop_a     = 1'b1;
                        state_nxt = DRAIN_B;
                    end else if (b_zero) begin
                        pop_b     = 1'b1;
                        state_nxt = DRAIN_A;
                    end else if (i_item_a >= i_item_b) begin
                        pop_a    = 1'b1;
                        emit     = 1'b1;
                        emit_dat = i_item_a;
                    end else begin
                        pop_b    = 1'b1;
                        emit     = 1'b1;
                        emit_dat = i_item_b;
                    end
                end
            end
            DRAIN_A: begin
                if (go && !i_empty_a) begin
                    pop_a    = 1'b1;
                    emit     = 1'b1;
                    emit_dat = i_item_a;
                    if (a_zero) state_nxt = MERGE;
                end
            end
            DRAIN_B: begin
                if (go && !i_empty_b) begin
                    pop_b    = 1'b1;
                    emit     = 1'b1;
                    emit_dat = i_item_b;
                    if (b_zero) state_nxt = MERGE;
                end
            end
            default: state_nxt = MERGE;
        endcase
    end

    // Reset must silence the pops combinationally, not just after the next edge
    assign o_read_a = pop_a && !i_rst;
    assign o_read_b = pop_b && !i_rst;
    assign o_state  = state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= MERGE;
            o_item  <= '0;
            o_write <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_write <= emit;
            if (emit) o_item <= emit_dat;
        end
    end

`ifdef MERGE_2TO1_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rec_count <= '0;
            o_run_count <= '0;
        end else if (emit) begin
            if (emit_dat == '0) o_run_count <= o_run_count + 16'd1;
            else                o_rec_count <= o_rec_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_merge_2to1.sv
// Directed bench for merge_2to1: queue-modelled upstream FIFOs, scoreboard of expected merged output.
module tb_merge_2to1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] item_a, item_b;
    logic        empty_a, empty_b, full;
    logic        read_a, read_b;
    logic [31:0] item;
    logic        write;
    logic [1:0]  state;
`ifdef MERGE_2TO1_STATS_EN
    logic [31:0] rec_count;
    logic [15:0] run_count;
`endif

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_item;
    logic [31:0] exp_rec;
    logic [15:0] exp_run;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    merge_2to1 #(.DATA_WIDTH(32)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_item_a  (item_a),
        .i_empty_a (empty_a),
        .o_read_a  (read_a),
        .i_item_b  (item_b),
        .i_empty_b (empty_b),
        .o_read_b  (read_b),
        .i_full    (full),
        .o_item    (item),
        .o_write   (write),
        .o_state   (state)
`ifdef MERGE_2TO1_STATS_EN
        ,
        .o_rec_count(rec_count),
        .o_run_count(run_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_stats();
`ifdef MERGE_2TO1_STATS_EN
        chk("rec_count", rec_count, exp_rec);
        chk("run_count", {16'd0, run_count}, {16'd0, exp_run});
`endif
    endtask

    // One clock: drive FIFO heads at negedge, capture pops, apply them at posedge, score output
    task automatic step(input logic f);
        logic        ra, rb;
        logic [31:0] e;
        @(negedge clk);
        full    = f;
        empty_a = (qa.size() == 0);
        empty_b = (qb.size() == 0);
        item_a  = empty_a ? 32'hFFFF_FFFF : qa[0];
        item_b  = empty_b ? 32'hFFFF_FFFF : qb[0];
        #1;
        ra = read_a;
        rb = read_b;
        if (f) chk("stall_pops", {30'd0, ra, rb}, 32'd0);
        if (ra && empty_a) chk("pop_empty_a", 32'd1, 32'd0);
        if (rb && empty_b) chk("pop_empty_b", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        if (ra && qa.size() != 0) void'(qa.pop_front());
        if (rb && qb.size() != 0) void'(qb.pop_front());
        if (f) chk("stall_write", {31'd0, write}, 32'd0);
        if (write) begin
            if (exp_q.size() == 0) begin
                chk("extra_write", item, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                chk("item", item, e);
                if (e == 0) exp_run = exp_run + 16'd1;
                else        exp_rec = exp_rec + 32'd1;
                chk_stats();
            end
        end else begin
            chk("item_hold", item, last_item);
        end
        last_item = item;
    endtask

    task automatic run_out(input int budget);
        for (int i = 0; i < budget && (qa.size() != 0 || qb.size() != 0 || exp_q.size() != 0); i++)
            step(1'b0);
        chk("drain_exp", exp_q.size(), 32'd0);
        chk("drain_fifos", qa.size() + qb.size(), 32'd0);
    endtask

    initial begin
        exp_rec   = '0;
        exp_run   = '0;
        last_item = '0;
        rst       = 1'b1;
        full      = 1'b0;
        item_a    = 32'd5;
        item_b    = 32'd3;
        empty_a   = 1'b0;
        empty_b   = 1'b0;
        #3;
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_item", item, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_reads", {30'd0, read_a, read_b}, 32'd0);
        chk_stats();
        repeat (2) @(negedge clk);
        empty_a = 1'b1;
        empty_b = 1'b1;
        rst     = 1'b0;

        // basic merge
        qa = '{32'd9, 32'd5, 32'd2, 32'd0};
        qb = '{32'd8, 32'd5, 32'd1, 32'd0};
        exp_q = '{32'd9, 32'd8, 32'd5, 32'd5, 32'd2, 32'd1, 32'd0};
        run_out(30);
        chk("basic_state", {30'd0, state}, 32'd0);

        // tie picks A
        qa = '{32'd5, 32'd0};
        qb = '{32'd5, 32'd0};
        exp_q = '{32'd5, 32'd5, 32'd0};
        step(1'b0);
        chk("tie_a_popped", qa.size(), 32'd1);
        chk("tie_b_kept", qb.size(), 32'd2);
        run_out(20);

        // unequal lengths
        qa = '{32'd7, 32'd0};
        qb = '{32'd6, 32'd4, 32'd3, 32'd0};
        exp_q = '{32'd7, 32'd6, 32'd4, 32'd3, 32'd0};
        step(1'b0);
        step(1'b0);
        chk("unequal_drain_b", {30'd0, state}, 32'd2);
        run_out(20);

        // empty run then back-to-back run
        qa = '{32'd0, 32'd3, 32'd0};
        qb = '{32'd2, 32'd0, 32'd0};
        exp_q = '{32'd2, 32'd0, 32'd3, 32'd0};
        step(1'b0);
        chk("empty_run_drain_b", {30'd0, state}, 32'd2);
        step(1'b0);
        step(1'b0);
        chk("run1_merge", {30'd0, state}, 32'd0);
        step(1'b0);
        chk("run2_drain_a", {30'd0, state}, 32'd1);
        step(1'b0);
        step(1'b0);
        chk("run2_merge", {30'd0, state}, 32'd0);
        run_out(10);

        // backpressure mid-stream
        qa = '{32'd9, 32'd5, 32'd2, 32'd0};
        qb = '{32'd8, 32'd5, 32'd1, 32'd0};
        exp_q = '{32'd9, 32'd8, 32'd5, 32'd5, 32'd2, 32'd1, 32'd0};
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        run_out(30);

        // stall on empty B
        qa = '{32'd4, 32'd0};
        repeat (5) step(1'b0);
        chk("stall_a_kept", qa.size(), 32'd2);
        qb = '{32'd6, 32'd0};
        exp_q = '{32'd6, 32'd4, 32'd0};
        run_out(20);

        // asynchronous reset while in DRAIN_A
        qa = '{32'd9, 32'd8, 32'd7, 32'd0};
        qb = '{32'd0};
        exp_q = '{32'd9};
        step(1'b0);
        step(1'b0);
        chk("pre_rst_state", {30'd0, state}, 32'd1);
        chk("pre_rst_write", {31'd0, write}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_write", {31'd0, write}, 32'd0);
        chk("mid_rst_item", item, 32'd0);
        chk("mid_rst_state", {30'd0, state}, 32'd0);
        chk("mid_rst_reads", {30'd0, read_a, read_b}, 32'd0);
        exp_rec = '0;
        exp_run = '0;
        chk_stats();
        @(negedge clk);
        rst       = 1'b0;
        last_item = '0;
        qb = '{32'd0};
        exp_q = '{32'd8, 32'd7, 32'd0};
        run_out(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
